// File: rtl/slot_sdram_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | slot_arb_pkg : shared state/grant types and relocation defaults for      |
// |                slot_sdram_arbiter (SLOT_ARB_TIMEOUT_EN adds TIMEOUT).     |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package slot_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LD   = 2'd1,
    GNT_A    = 2'd2,
    GNT_B    = 2'd3
  } grant_t;

  localparam logic [24:0] BASE_A_DEFAULT = 25'h0400000;
  localparam logic [24:0] BASE_B_DEFAULT = 25'h0000000;
`ifdef SLOT_ARB_TIMEOUT_EN
  localparam logic [7:0]  TIMEOUT_DEFAULT = 8'd255;
`endif

  // Slot offsets are zero-extended; the sum wraps at 25 bits.
  function automatic logic [24:0] relocate(input logic [24:0] base, input logic [21:0] off);
    return base + {3'b000, off};
  endfunction

endpackage
`default_nettype wire

// File: rtl/slot_sdram_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | slot_arb_rr : 2-way round-robin picker between cartridge slots A and B.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module slot_arb_rr
  import slot_arb_pkg::*;
(
  input  logic   i_req_a,
  input  logic   i_req_b,
  input  logic   i_rr_last_b,
  input  logic   i_advance,
  output grant_t o_pick
);

  always_comb begin
    o_pick = GNT_NONE;
    if (i_advance) begin
      // On a tie, the slot that was not served last wins.
      if (i_req_a && i_req_b) begin
        o_pick = i_rr_last_b ? GNT_A : GNT_B;
      end else if (i_req_a) begin
        o_pick = GNT_A;
      end else if (i_req_b) begin
        o_pick = GNT_B;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/slot_sdram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | slot_sdram_arbiter : shares one byte-wide SDRAM port between the ROM     |
// |   loader and cartridge slots A/B. Optional SLOT_ARB_TIMEOUT_EN bounds    |
// |   the WAIT state.                                                        |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module slot_sdram_arbiter
  import slot_arb_pkg::*;
#(
  parameter logic [24:0] BASE_A = BASE_A_DEFAULT,
  parameter logic [24:0] BASE_B = BASE_B_DEFAULT
`ifdef SLOT_ARB_TIMEOUT_EN
  ,
  parameter logic [7:0]  TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_wr_req,
  input  logic [24:0] ld_addr,
  input  logic [7:0]  ld_din,
  output logic        ld_ack,
  input  logic        a_rd_req,
  input  logic [21:0] a_addr,
  output logic [7:0]  a_dout,
  output logic        a_ack,
  input  logic        b_rd_req,
  input  logic [21:0] b_addr,
  output logic [7:0]  b_dout,
  output logic        b_ack,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_din,
  output logic        sdram_we,
  output logic        sdram_rd,
  input  logic        sdram_ready,
  input  logic [7:0]  sdram_dout,
  output logic        busy,
  output logic [1:0]  grant
);

  arb_state_t  r_state;
  grant_t      r_owner;
  grant_t      r_grant;
  logic        r_rr_last_b;
  logic [24:0] r_addr;
  logic [7:0]  r_din;
  logic        r_we;
  logic        r_rd;
  logic        r_ld_ack;
  logic        r_a_ack;
  logic        r_b_ack;
  logic [7:0]  r_a_dout;
  logic [7:0]  r_b_dout;

  grant_t      w_pick;
  logic        w_slot_turn;
  logic        w_fin;
  logic [7:0]  w_rdata;
  logic [24:0] w_slot_addr;

  assign w_slot_turn = (r_state == IDLE) && !ld_wr_req;

  slot_arb_rr u_rr (
    .i_req_a     (a_rd_req),
    .i_req_b     (b_rd_req),
    .i_rr_last_b (r_rr_last_b),
    .i_advance   (w_slot_turn),
    .o_pick      (w_pick)
  );

  assign w_slot_addr = (w_pick == GNT_B) ? relocate(BASE_B, b_addr) : relocate(BASE_A, a_addr);

`ifdef SLOT_ARB_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       w_timeout;

  // A hung controller still releases the requester with an all-ones byte.
  assign w_timeout = !sdram_ready && (r_to_cnt == (TIMEOUT - 8'd1));
  assign w_fin     = sdram_ready || w_timeout;
  assign w_rdata   = sdram_ready ? sdram_dout : 8'hFF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= 8'd0;
    end else if ((r_state != WAIT) || w_fin) begin
      r_to_cnt <= 8'd0;
    end else begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end
`else
  assign w_fin   = sdram_ready;
  assign w_rdata = sdram_dout;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_owner     <= GNT_NONE;
      r_grant     <= GNT_NONE;
      r_rr_last_b <= 1'b1;
      r_addr      <= 25'd0;
      r_din       <= 8'd0;
      r_we        <= 1'b0;
      r_rd        <= 1'b0;
      r_ld_ack    <= 1'b0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_dout    <= 8'hFF;
      r_b_dout    <= 8'hFF;
    end else begin
      r_we     <= 1'b0;
      r_rd     <= 1'b0;
      r_ld_ack <= 1'b0;
      r_a_ack  <= 1'b0;
      r_b_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ld_wr_req) begin
            r_owner <= GNT_LD;
            r_grant <= GNT_LD;
            r_addr  <= ld_addr;
            r_din   <= ld_din;
            r_we    <= 1'b1;
            r_state <= ISSUE;
          end else if (w_pick != GNT_NONE) begin
            r_owner <= w_pick;
            r_grant <= w_pick;
            r_addr  <= w_slot_addr;
            r_din   <= 8'd0;
            r_rd    <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_fin) begin
            r_state <= DONE;
            r_grant <= GNT_NONE;
            case (r_owner)
              GNT_LD: r_ld_ack <= 1'b1;
              GNT_A: begin
                r_a_ack     <= 1'b1;
                r_a_dout    <= w_rdata;
                r_rr_last_b <= 1'b0;
              end
              GNT_B: begin
                r_b_ack     <= 1'b1;
                r_b_dout    <= w_rdata;
                r_rr_last_b <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        DONE: begin
          r_owner <= GNT_NONE;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sdram_addr = r_addr;
  assign sdram_din  = r_din;
  assign sdram_we   = r_we;
  assign sdram_rd   = r_rd;
  assign ld_ack     = r_ld_ack;
  assign a_ack      = r_a_ack;
  assign b_ack      = r_b_ack;
  assign a_dout     = r_a_dout;
  assign b_dout     = r_b_dout;
  assign busy       = (r_state != IDLE);
  assign grant      = r_grant;

endmodule
`default_nettype wire
